lsm_sequencer: RTL and testbench

- Initiator side of the data-memory interface; implements the multi-register LM (load multiple) and SM (store multiple) instructions.
- Takes a base address and an 8-bit register list, then issues one memory access per selected register, lowest register first, at consecutive addresses.
- Sits between the decode/execute stage, the register file and the data memory. The memory is a combinational-read, write-on-Write_Read=1 responder.

---
 rtl/lsm_sequencer.sv | 128 ++++++++++++
 tb/tb_lsm_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks an 8-bit register list lowest-first and
// issues one data-memory access per selected register at consecutive addresses.
module lsm_sequencer #(
   parameter int REG_COUNT = 8,
   parameter int ADDR_STEP = 1,
   parameter int DATA_W    = 16,
   localparam int IDX_W    = $clog2(REG_COUNT),
   localparam int CNT_W    = $clog2(REG_COUNT + 1),
   localparam int ADDR_W   = 16
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic                 Start,
   input  logic                 Is_Store,
   input  logic [ADDR_W-1:0]    Base_Address,
   input  logic [REG_COUNT-1:0] Reg_List,
   output logic                 Busy,
   output logic                 Done,
   output logic [CNT_W-1:0]     Transfer_Count,
   output logic [IDX_W-1:0]     Rf_Read_Addr,
   input  logic [DATA_W-1:0]    Rf_Read_Data,
   output logic                 Rf_Write_En,
   output logic [IDX_W-1:0]     Rf_Write_Addr,
   output logic [DATA_W-1:0]    Rf_Write_Data,
   output logic [ADDR_W-1:0]    Mem_Address,
   output logic [DATA_W-1:0]    Mem_Write_Data,
   output logic                 Mem_Write_Read,
   input  logic [DATA_W-1:0]    Mem_Read_Data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_p0;
   state_t                 state_d;
   logic [REG_COUNT-1:0]   pending_p0;
   logic [ADDR_W-1:0]      addr_p0;
   logic                   is_store_p0;
   logic [CNT_W-1:0]       count_p0;

   logic [IDX_W-1:0]       idx;
   logic [REG_COUNT-1:0]   pending_next;

   // Scan from the top down so the last hit is the lowest set bit.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [REG_COUNT-1:0] list);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = REG_COUNT - 1; i >= 0; i--) begin
         if (list[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   assign idx          = lowest_idx(pending_p0);
   assign pending_next = pending_p0 & ~(REG_COUNT'(1) << idx);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_p0    <= IDLE;
         pending_p0  <= '0;
         addr_p0     <= '0;
         is_store_p0 <= 1'b0;
         count_p0    <= '0;
      end else begin
         state_p0 <= state_d;
         case (state_p0)
            IDLE: begin
               if (Start) begin
                  pending_p0  <= Reg_List;
                  addr_p0     <= Base_Address;
                  is_store_p0 <= Is_Store;
                  count_p0    <= '0;
               end
            end
            XFER: begin
               pending_p0 <= pending_next;
               addr_p0    <= addr_p0 + ADDR_W'(ADDR_STEP);
               count_p0   <= count_p0 + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_p0;
      case (state_p0)
         IDLE: begin
            if (Start) state_d = (Reg_List != '0) ? XFER : DONE;
         end
         XFER: begin
            if (pending_next == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode from the registered state only, so reset clears them at once.
   always_comb begin
      Busy           = (state_p0 == XFER) || (state_p0 == DONE);
      Done           = (state_p0 == DONE);
      Transfer_Count = count_p0;
      Rf_Read_Addr   = '0;
      Rf_Write_En    = 1'b0;
      Rf_Write_Addr  = '0;
      Rf_Write_Data  = '0;
      Mem_Address    = '0;
      Mem_Write_Data = '0;
      Mem_Write_Read = 1'b0;
      if (state_p0 == XFER) begin
         Mem_Address = addr_p0;
         if (is_store_p0) begin
            Rf_Read_Addr   = idx;
            Mem_Write_Data = Rf_Read_Data;
            Mem_Write_Read = 1'b1;
         end else begin
            Rf_Write_En   = 1'b1;
            Rf_Write_Addr = idx;
            Rf_Write_Data = Mem_Read_Data;
         end
      end
   end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: directed and randomized LM/SM operations against a
// list-walking reference model, with a behavioural memory and register file.
module tb_lsm_sequencer;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic        Is_Store;
   logic [15:0] Base_Address;
   logic [7:0]  Reg_List;
   logic        Busy;
   logic        Done;
   logic [3:0]  Transfer_Count;
   logic [2:0]  Rf_Read_Addr;
   logic [15:0] Rf_Read_Data;
   logic        Rf_Write_En;
   logic [2:0]  Rf_Write_Addr;
   logic [15:0] Rf_Write_Data;
   logic [15:0] Mem_Address;
   logic [15:0] Mem_Write_Data;
   logic        Mem_Write_Read;
   logic [15:0] Mem_Read_Data;

   logic [15:0] mem [0:65535];
   logic [15:0] rf  [0:7];
   logic        pre_mem_en = 1'b0;
   logic        pre_rf_en  = 1'b0;
   logic [15:0] pre_addr   = '0;
   logic [2:0]  pre_idx    = '0;
   logic [15:0] pre_data   = '0;
   int          wr_count   = 0;
   int          rfw_count  = 0;
   int          n_assert   = 0;
   int          n_fail     = 0;

   lsm_sequencer dut (
      .Clock          (Clock),
      .Reset_n        (Reset_n),
      .Start          (Start),
      .Is_Store       (Is_Store),
      .Base_Address   (Base_Address),
      .Reg_List       (Reg_List),
      .Busy           (Busy),
      .Done           (Done),
      .Transfer_Count (Transfer_Count),
      .Rf_Read_Addr   (Rf_Read_Addr),
      .Rf_Read_Data   (Rf_Read_Data),
      .Rf_Write_En    (Rf_Write_En),
      .Rf_Write_Addr  (Rf_Write_Addr),
      .Rf_Write_Data  (Rf_Write_Data),
      .Mem_Address    (Mem_Address),
      .Mem_Write_Data (Mem_Write_Data),
      .Mem_Write_Read (Mem_Write_Read),
      .Mem_Read_Data  (Mem_Read_Data)
   );

   always #5 Clock = ~Clock;

   assign Rf_Read_Data  = rf[Rf_Read_Addr];
   assign Mem_Read_Data = mem[Mem_Address];

   // Memory and register file respond to the DUT, or to bench preloads.
   always @(posedge Clock) begin
      if (pre_mem_en) mem[pre_addr] <= pre_data;
      else if (Mem_Write_Read === 1'b1) begin
         mem[Mem_Address] <= Mem_Write_Data;
         wr_count <= wr_count + 1;
      end
      if (pre_rf_en) rf[pre_idx] <= pre_data;
      else if (Rf_Write_En === 1'b1) begin
         rf[Rf_Write_Addr] <= Rf_Write_Data;
         rfw_count <= rfw_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke_rf(input logic [2:0] i, input logic [15:0] d);
      pre_rf_en = 1'b1; pre_idx = i; pre_data = d;
      @(posedge Clock); @(negedge Clock);
      pre_rf_en = 1'b0;
   endtask

   task automatic poke_mem(input logic [15:0] a, input logic [15:0] d);
      pre_mem_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge Clock); @(negedge Clock);
      pre_mem_en = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_wr"},    32'(Mem_Write_Read), 32'd0);
      chk({tag, "_rfwe"},  32'(Rf_Write_En),    32'd0);
      chk({tag, "_addr"},  32'(Mem_Address),    32'd0);
      chk({tag, "_wdata"}, 32'(Mem_Write_Data), 32'd0);
      chk({tag, "_rfwd"},  32'(Rf_Write_Data),  32'd0);
   endtask

   // One operation, entered and left at a negedge. inject = cycle (0..N-1 in
   // XFER, N in DONE) at which a competing Start is driven; -1 for none.
   task automatic run_op(input string tag, input bit st, input logic [15:0] base,
                         input logic [7:0] list, input int inject);
      int          idxs[$];
      logic [15:0] addrs[$];
      logic [15:0] datas[$];
      int          n, w0, r0, k;
      k = 0;
      for (int b = 0; b < 8; b++) begin
         if (list[b]) begin
            idxs.push_back(b);
            addrs.push_back(base + 16'(k));
            k++;
         end
      end
      n = idxs.size();
      for (int j = 0; j < n; j++) datas.push_back(st ? rf[idxs[j]] : mem[addrs[j]]);
      w0 = wr_count;
      r0 = rfw_count;
      Start = 1'b1; Is_Store = st; Base_Address = base; Reg_List = list;
      @(posedge Clock); @(negedge Clock);
      for (int j = 0; j < n; j++) begin
         Start        = (inject == j);
         Reg_List     = 8'($urandom) | 8'h01;
         Base_Address = 16'($urandom);
         Is_Store     = 1'($urandom);
         chk({tag, "_busy"},  32'(Busy),           32'd1);
         chk({tag, "_done"},  32'(Done),           32'd0);
         chk({tag, "_cnt"},   32'(Transfer_Count), 32'(j));
         chk({tag, "_maddr"}, 32'(Mem_Address),    32'(addrs[j]));
         chk({tag, "_wr"},    32'(Mem_Write_Read), 32'(st));
         chk({tag, "_rfwe"},  32'(Rf_Write_En),    32'(!st));
         if (st) begin
            chk({tag, "_rdidx"}, 32'(Rf_Read_Addr),   32'(idxs[j]));
            chk({tag, "_wdata"}, 32'(Mem_Write_Data), 32'(datas[j]));
         end else begin
            chk({tag, "_wridx"}, 32'(Rf_Write_Addr), 32'(idxs[j]));
            chk({tag, "_rfwd"},  32'(Rf_Write_Data), 32'(datas[j]));
         end
         @(posedge Clock); @(negedge Clock);
      end
      Start = (inject == n);
      chk({tag, "_dn_done"}, 32'(Done),           32'd1);
      chk({tag, "_dn_busy"}, 32'(Busy),           32'd1);
      chk({tag, "_dn_cnt"},  32'(Transfer_Count), 32'(n));
      chk_quiet({tag, "_dn"});
      @(posedge Clock); @(negedge Clock);
      Start = 1'b0;
      chk({tag, "_id_busy"}, 32'(Busy),           32'd0);
      chk({tag, "_id_done"}, 32'(Done),           32'd0);
      chk({tag, "_id_cnt"},  32'(Transfer_Count), 32'(n));
      chk_quiet({tag, "_id"});
      chk({tag, "_nwr"},  32'(wr_count - w0),  st ? 32'(n) : 32'd0);
      chk({tag, "_nrfw"}, 32'(rfw_count - r0), st ? 32'd0 : 32'(n));
      for (int j = 0; j < n; j++) begin
         if (st) chk({tag, "_memres"}, 32'(mem[addrs[j]]), 32'(datas[j]));
         else    chk({tag, "_rfres"},  32'(rf[idxs[j]]),   32'(datas[j]));
      end
   endtask

   initial begin
      int w0;
      Reset_n = 1'b0; Start = 1'b0; Is_Store = 1'b0;
      Base_Address = '0; Reg_List = '0;
      repeat (3) @(negedge Clock);
      chk("rst_busy", 32'(Busy),           32'd0);
      chk("rst_done", 32'(Done),           32'd0);
      chk("rst_cnt",  32'(Transfer_Count), 32'd0);
      chk("rst_rdix", 32'(Rf_Read_Addr),   32'd0);
      chk("rst_wrix", 32'(Rf_Write_Addr),  32'd0);
      chk_quiet("rst");
      Reset_n = 1'b1;
      @(negedge Clock);

      // Directed: SM then LM over the same memory words
      poke_rf(3'd0, 16'hAAAA);
      poke_rf(3'd2, 16'h5555);
      run_op("sm_basic", 1'b1, 16'h0004, 8'b0000_0101, -1);
      chk("sm_mem4", 32'(mem[16'h0004]), 32'h0000AAAA);
      chk("sm_mem5", 32'(mem[16'h0005]), 32'h00005555);
      poke_rf(3'd0, 16'h0000);
      poke_rf(3'd7, 16'h0000);
      run_op("lm_basic", 1'b0, 16'h0004, 8'b1000_0001, -1);
      chk("lm_r0", 32'(rf[0]), 32'h0000AAAA);
      chk("lm_r7", 32'(rf[7]), 32'h00005555);

      run_op("sm_empty", 1'b1, 16'h1234, 8'h00, -1);
      run_op("lm_empty", 1'b0, 16'h4321, 8'h00, 0);

      for (int i = 0; i < 8; i++) poke_rf(3'(i), 16'($urandom));
      run_op("sm_wrap", 1'b1, 16'hFFFF, 8'hFF, -1);

      for (int i = 0; i < 8; i++) poke_rf(3'(i), 16'($urandom));
      run_op("sm_ign_xfer", 1'b1, 16'h0200, 8'b0110_1010, 1);
      for (int i = 0; i < 3; i++) poke_mem(16'h0300 + 16'(i), 16'($urandom));
      run_op("lm_ign_done", 1'b0, 16'h0300, 8'b0001_0110, 3);

      // Randomized operations
      for (int t = 0; t < 14; t++) begin
         bit          st;
         logic [15:0] base;
         logic [7:0]  list;
         int          inj;
         st   = 1'($urandom);
         base = 16'($urandom);
         list = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         inj  = int'($urandom_range(0, 9)) - 1;
         if (st) begin
            for (int i = 0; i < 8; i++) poke_rf(3'(i), 16'($urandom));
         end else begin
            for (int i = 0; i < $countones(list); i++) poke_mem(base + 16'(i), 16'($urandom));
         end
         run_op(st ? "rnd_sm" : "rnd_lm", st, base, list, inj);
      end

      // Reset during the second XFER cycle of an 8-register store
      for (int i = 0; i < 8; i++) poke_rf(3'(i), 16'($urandom));
      w0 = wr_count;
      Start = 1'b1; Is_Store = 1'b1; Base_Address = 16'h0100; Reg_List = 8'hFF;
      @(posedge Clock); @(negedge Clock);
      Start = 1'b0;
      chk("ab_c1_addr", 32'(Mem_Address), 32'h00000100);
      @(posedge Clock); @(negedge Clock);
      chk("ab_c2_addr", 32'(Mem_Address),    32'h00000101);
      chk("ab_c2_wr",   32'(Mem_Write_Read), 32'd1);
      Reset_n = 1'b0;
      #1;
      chk("ab_busy", 32'(Busy),           32'd0);
      chk("ab_cnt",  32'(Transfer_Count), 32'd0);
      chk_quiet("ab");
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clock);
      chk("ab_post_busy", 32'(Busy),           32'd0);
      chk("ab_post_done", 32'(Done),           32'd0);
      chk("ab_post_wr",   32'(Mem_Write_Read), 32'd0);
      chk("ab_post_nwr",  32'(wr_count - w0),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
